// File: rtl/pvmae_pkg.sv
// Shared constants and types for the high-pass envelope detector.
// Holds the FSM state encoding and the sample width.
package pvmae_pkg;

  localparam int SAMPLE_W = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    QUAL    = 2'd1,
    ACTIVE  = 2'd2,
    HOLDOFF = 2'd3
  } state_t;

  function automatic int unsigned umax(
    input int unsigned a,
    input int unsigned b
  );
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/abs_sat.sv
// Signed-to-unsigned absolute value.
// The most negative input clamps to the largest positive value.
module abs_sat
  import pvmae_pkg::*;
(
  input  logic signed [SAMPLE_W-1:0] i_x,
  output logic        [SAMPLE_W-1:0] o_abs
);

  localparam logic [SAMPLE_W-1:0] MIN_NEG =
    {1'b1, {(SAMPLE_W-1){1'b0}}};
  localparam logic [SAMPLE_W-1:0] MAX_POS =
    {1'b0, {(SAMPLE_W-1){1'b1}}};

  logic [SAMPLE_W-1:0] w_raw;

  assign w_raw = i_x;

  always_comb begin
    o_abs = w_raw;
    if (i_x[SAMPLE_W-1]) begin
      if (w_raw == MIN_NEG) o_abs = MAX_POS;
      else                  o_abs = (~w_raw) + 1'b1;
    end
  end

endmodule

// File: rtl/hpf_env_detect.sv
// Envelope detector behind the biquad high-pass stage: rectify,
// leaky-integrate, then qualify threshold crossings with an FSM.
module hpf_env_detect
  import pvmae_pkg::*;
#(
  parameter int unsigned SHIFT       = 4,
  parameter int unsigned THRESH_ON   = 4096,
  parameter int unsigned THRESH_OFF  = 2048,
  parameter int unsigned HOLD_CYC    = 16,
  parameter int unsigned HOLDOFF_CYC = 64
)(
  input  logic                       insclk,
  input  logic                       rstn,
  input  logic signed [SAMPLE_W-1:0] y2,
  output logic                       outsclk,
  output logic        [SAMPLE_W-1:0] env,
  output logic                       event_lvl,
  output logic                       event_pulse,
  output logic        [SAMPLE_W-1:0] peak,
  output logic        [15:0]         evt_count
);

  localparam int unsigned CNT_W =
    $clog2(umax(HOLD_CYC, HOLDOFF_CYC) + 1);

  localparam logic [CNT_W-1:0] HOLD_N = CNT_W'(HOLD_CYC);
  localparam logic [CNT_W-1:0] HOFF_N = CNT_W'(HOLDOFF_CYC);
  localparam logic [CNT_W-1:0] CNT_1  = CNT_W'(1);

  localparam logic [SAMPLE_W-1:0] TON  = SAMPLE_W'(THRESH_ON);
  localparam logic [SAMPLE_W-1:0] TOFF = SAMPLE_W'(THRESH_OFF);

  if (THRESH_OFF > THRESH_ON) begin : g_bad_thresh
    $error("hpf_env_detect: THRESH_OFF > THRESH_ON");
  end

  if (SHIFT < 1 || SHIFT > 15) begin : g_bad_shift
    $error("hpf_env_detect: SHIFT outside 1..15");
  end

  logic [SAMPLE_W-1:0] w_abs;
  logic [SAMPLE_W-1:0] r_abs;
  logic [SAMPLE_W-1:0] r_env;
  logic [SAMPLE_W-1:0] w_env_nxt;
  logic signed [SAMPLE_W:0] w_diff;
  logic signed [SAMPLE_W:0] w_step;
  logic signed [SAMPLE_W:0] w_sum;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic                r_pulse;
  logic                w_pulse_nxt;
  logic [SAMPLE_W-1:0] r_peak;
  logic [SAMPLE_W-1:0] w_peak_nxt;
  logic [15:0]         r_evt_count;
  logic                w_inc;
  logic                w_ge_on;
  logic                w_lt_off;

  abs_sat u_abs (
    .i_x   (y2),
    .o_abs (w_abs)
  );

  // Step toward abs_r; the result always lies between env and abs_r.
  assign w_diff    = $signed({1'b0, r_abs}) - $signed({1'b0, r_env});
  assign w_step    = w_diff >>> SHIFT;
  assign w_sum     = $signed({1'b0, r_env}) + w_step;
  assign w_env_nxt = w_sum[SAMPLE_W-1:0];

  assign w_ge_on  = (r_env >= TON);
  assign w_lt_off = (r_env <  TOFF);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pulse_nxt = 1'b0;
    w_peak_nxt  = r_peak;
    w_inc       = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_ge_on) begin
          w_state_nxt = QUAL;
          w_cnt_nxt   = CNT_1;
        end
      end
      QUAL: begin
        if (w_lt_off) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == HOLD_N) begin
          w_state_nxt = ACTIVE;
          w_cnt_nxt   = '0;
          w_pulse_nxt = 1'b1;
          w_peak_nxt  = r_env;
          w_inc       = (r_evt_count != 16'hFFFF);
        end else begin
          w_cnt_nxt = r_cnt + CNT_1;
        end
      end
      ACTIVE: begin
        if (r_env > r_peak) w_peak_nxt = r_env;
        if (w_lt_off) begin
          w_state_nxt = HOLDOFF;
          w_cnt_nxt   = CNT_1;
        end
      end
      HOLDOFF: begin
        if (r_cnt == HOFF_N) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge insclk or negedge rstn) begin
    if (!rstn) begin
      r_abs   <= '0;
      r_env   <= '0;
      r_state <= IDLE;
      r_cnt   <= '0;
      r_pulse <= 1'b0;
      r_peak  <= '0;
    end else begin
      r_abs   <= w_abs;
      r_env   <= w_env_nxt;
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_pulse <= w_pulse_nxt;
      r_peak  <= w_peak_nxt;
    end
  end

  // Written only on increment so the count is held between events.
  always_ff @(posedge insclk or negedge rstn) begin
    if (!rstn) begin
      r_evt_count <= '0;
    end else if (w_inc) begin
      r_evt_count <= r_evt_count + 16'd1;
    end
  end

  assign outsclk     = insclk;
  assign env         = r_env;
  assign event_lvl   = (r_state == ACTIVE);
  assign event_pulse = r_pulse;
  assign peak        = r_peak;
  assign evt_count   = r_evt_count;

endmodule

// File: tb/tb_hpf_env_detect.sv
// Directed bench for hpf_env_detect: step responses, hysteresis,
// holdoff, short bursts, async reset and counter saturation.
module tb_hpf_env_detect;
  import pvmae_pkg::*;

  logic               clk  = 1'b0;
  logic               rstn = 1'b0;
  logic signed [31:0] y2   = '0;
  logic               outsclk;
  logic [31:0]        env;
  logic               evt;
  logic               pulse;
  logic [31:0]        peak;
  logic [15:0]        ecnt;

  int n_cmp = 0;
  int n_bad = 0;

  longint m_env = 0;
  longint m_abs = 0;
  longint m_pre = 0;

  always #5 clk = ~clk;

  hpf_env_detect dut (
    .insclk      (clk),
    .rstn        (rstn),
    .y2          (y2),
    .outsclk     (outsclk),
    .env         (env),
    .event_lvl   (evt),
    .event_pulse (pulse),
    .peak        (peak),
    .evt_count   (ecnt)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic longint mabs(input logic signed [31:0] v);
    if (v == 32'sh8000_0000) return 64'h7FFF_FFFF;
    if (v < 0) return -longint'(v);
    return longint'(v);
  endfunction

  task automatic tick();
    m_pre = m_env;
    m_env = m_env + ((m_abs - m_env) >>> 4);
    m_abs = mabs(y2);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    y2    = '0;
    rstn  = 1'b0;
    m_env = 0;
    m_abs = 0;
    m_pre = 0;
    repeat (2) @(posedge clk);
    #2;
    rstn = 1'b1;
  endtask

  task automatic step(
    input logic signed [31:0] v,
    input logic [15:0]        exp_cnt
  );
    y2 = v;
    tick();
    chk("s_abs", dut.r_abs, 32'(mabs(v)));
    chk("s_env0", env, 32'd0);
    tick();
    chk("s_env1", env, 32'(mabs(v) >>> 4));
    tick();
    chk("s_qual", 32'(dut.r_state), 32'(QUAL));
    chk("s_qcnt", 32'(dut.r_cnt), 32'd1);
    repeat (15) tick();
    chk("s_evt17", 32'(evt), 32'd0);
    chk("s_pls17", 32'(pulse), 32'd0);
    tick();
    chk("s_evt18", 32'(evt), 32'd1);
    chk("s_pls18", 32'(pulse), 32'd1);
    chk("s_cnt18", 32'(ecnt), 32'(exp_cnt));
    chk("s_peak18", peak, 32'(m_pre));
    tick();
    chk("s_pls19", 32'(pulse), 32'd0);
    chk("s_evt19", 32'(evt), 32'd1);
    chk("s_peak19", peak, 32'(m_pre));
  endtask

  task automatic wait_fall(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (m_pre < 2048) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    bit seen;
    bit saw_q;
    bit saw_e;

    // Reset state and quiet input
    do_reset();
    chk("rst_env", env, 32'd0);
    chk("rst_evt", 32'(evt), 32'd0);
    chk("rst_pls", 32'(pulse), 32'd0);
    chk("rst_peak", peak, 32'd0);
    chk("rst_cnt", 32'(ecnt), 32'd0);
    chk("rst_st", 32'(dut.r_state), 32'(IDLE));
    chk("clk_pass", 32'(outsclk), 32'(clk));
    for (int i = 0; i < 200; i++) begin
      tick();
      chk("q_env", env, 32'd0);
      chk("q_evt", 32'(evt), 32'd0);
      chk("q_cnt", 32'(ecnt), 32'd0);
    end

    // Positive step
    step(32'sd65536, 16'd1);

    // Fall, holdoff, re-trigger
    y2 = '0;
    wait_fall(ok);
    chk("h_found", 32'(ok), 32'd1);
    chk("h_evt", 32'(evt), 32'd0);
    chk("h_st", 32'(dut.r_state), 32'(HOLDOFF));
    chk("h_cnt", 32'(dut.r_cnt), 32'd1);
    chk("h_env", env, 32'(m_env));
    seen = 1'b0;
    for (int k = 1; k <= 63; k++) begin
      if (k == 10) y2 = 32'sd65536;
      tick();
      seen = seen | pulse | evt;
    end
    chk("h_st63", 32'(dut.r_state), 32'(HOLDOFF));
    chk("h_quiet", 32'(seen), 32'd0);
    tick();
    chk("h_st64", 32'(dut.r_state), 32'(IDLE));
    tick();
    chk("h_st65", 32'(dut.r_state), 32'(QUAL));
    repeat (15) tick();
    chk("h2_evt_b", 32'(evt), 32'd0);
    tick();
    chk("h2_evt", 32'(evt), 32'd1);
    chk("h2_pls", 32'(pulse), 32'd1);
    chk("h2_cnt", 32'(ecnt), 32'd2);

    // Short burst does not make an event
    y2 = '0;
    wait_fall(ok);
    chk("b_found", 32'(ok), 32'd1);
    repeat (80) tick();
    chk("b_idle", 32'(dut.r_state), 32'(IDLE));
    chk("b_env", env, 32'(m_env));
    y2 = 32'sd70000;
    tick();
    y2 = '0;
    saw_q = 1'b0;
    saw_e = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (dut.r_state == QUAL) saw_q = 1'b1;
      if (evt || pulse) saw_e = 1'b1;
    end
    chk("b_qual", 32'(saw_q), 32'd1);
    chk("b_noevt", 32'(saw_e), 32'd0);
    chk("b_cnt", 32'(ecnt), 32'd2);
    chk("b_end", 32'(dut.r_state), 32'(IDLE));

    // Negative step, identical timing
    do_reset();
    step(-32'sd65536, 16'd1);

    // Most negative sample saturates
    do_reset();
    y2 = 32'sh8000_0000;
    tick();
    chk("m_abs", dut.r_abs, 32'h7FFF_FFFF);
    tick();
    chk("m_env1", env, 32'h07FF_FFFF);
    repeat (300) tick();
    chk("m_env", env, 32'(m_env));
    chk("m_nowrap", 32'(env[31]), 32'd0);

    // Async reset mid-event
    do_reset();
    step(32'sd65536, 16'd1);
    repeat (3) tick();
    #2;
    rstn = 1'b0;
    #1;
    chk("a_evt", 32'(evt), 32'd0);
    chk("a_pls", 32'(pulse), 32'd0);
    chk("a_env", env, 32'd0);
    chk("a_peak", peak, 32'd0);
    chk("a_cnt", 32'(ecnt), 32'd0);

    // Counter saturation
    do_reset();
    force dut.r_evt_count = 16'hFFFF;
    #1;
    release dut.r_evt_count;
    chk("f_pre", 32'(ecnt), 32'h0000_FFFF);
    step(32'sd65536, 16'hFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
